// File: rtl/vga_scroll_pattern_gen.sv
// VGA timing plus scrolling test-pattern source. Every output is registered 1 clk after the h/v counter state.
// Free-running: there is no backpressure, and scroll, mode and pause are only sampled on the last clock of a frame.
module vga_scroll_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int OFF_W    = 10,
  parameter int SPD_W    = 4,
  parameter int CHK      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [SPD_W-1:0] dx,
  input  logic [SPD_W-1:0] dy,
  input  logic             pause,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic [1:0]       r,
  output logic [1:0]       g,
  output logic [1:0]       b,
  output logic             frame_tick
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int PW0   = (OFF_W > 8) ? OFF_W : 8;
  localparam int PW    = (PW0 > CHK + 1) ? PW0 : CHK + 1;

  logic [HW-1:0]           hc;
  logic [VW-1:0]           vc;
  logic [OFF_W-1:0]        xo, yo;
  logic [7:0]              fc;
  logic [1:0]              mode_s;
  logic signed [SPD_W-1:0] step_x, step_y;
  logic                    ft, active, hs_on, vs_on, c;
  logic [OFF_W-1:0]        mx, my;
  logic [PW-1:0]           mxe, mye, t;
  logic [1:0]              r_n, g_n, b_n;
  logic                    unused_bits;

  assign ft     = (hc == HW'(H_TOT - 1)) && (vc == VW'(V_TOT - 1));
  assign active = (hc < HW'(H_ACTIVE)) && (vc < VW'(V_ACTIVE));
  assign hs_on  = (hc >= HW'(H_ACTIVE + H_FP)) && (hc <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
  assign vs_on  = (vc >= VW'(V_ACTIVE + V_FP)) && (vc <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == HW'(H_TOT - 1)) begin
      hc <= '0;
      vc <= (vc == VW'(V_TOT - 1)) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // dx/dy/pause are consumed at the tick that samples them; only mode needs a held copy.
  assign step_x = dx;
  assign step_y = dy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xo     <= '0;
      yo     <= '0;
      fc     <= '0;
      mode_s <= '0;
    end else if (ft) begin
      mode_s <= mode;
      fc     <= fc + 8'd1;
      if (!pause) begin
        xo <= xo + OFF_W'(step_x);
        yo <= yo + OFF_W'(step_y);
      end
    end
  end

  // Zero-extend the scrolled coordinates so the fixed pattern bit picks stay legal for narrow OFF_W.
  assign mx  = OFF_W'(hc) + xo;
  assign my  = OFF_W'(vc) + yo;
  assign mxe = PW'(mx);
  assign mye = PW'(my);
  assign t   = mxe ^ mye;
  assign c   = mxe[CHK] ^ mye[CHK];

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (active) begin
      case (mode_s)
        2'd0: begin
          r_n = {mxe[5], mye[2]};
          g_n = {mxe[6], mye[2]};
          b_n = {mxe[7], mye[5]};
        end
        2'd1: begin
          r_n = {c, c};
          g_n = {c, c};
          b_n = {c, c};
        end
        2'd2: begin
          r_n = t[7:6];
          g_n = t[5:4];
          b_n = t[3:2];
        end
        default: begin
          r_n = fc[7:6];
          g_n = fc[5:4];
          b_n = fc[3:2];
        end
      endcase
    end
  end

  assign unused_bits = ^{fc[1:0], t, mxe, mye};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      display_on <= 1'b0;
      r          <= '0;
      g          <= '0;
      b          <= '0;
      frame_tick <= 1'b0;
    end else begin
      hsync      <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync      <= vs_on ? SYNC_POL : ~SYNC_POL;
      display_on <= active;
      r          <= r_n;
      g          <= g_n;
      b          <= b_n;
      frame_tick <= ft;
    end
  end

endmodule

// File: tb/tb_vga_scroll_pattern_gen.sv
// Bench for vga_scroll_pattern_gen on a 14x7 timing grid with a 4-bit offset space.
module tb_vga_scroll_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] dx = 4'd0, dy = 4'd0;
  logic       pause = 1'b0;
  logic       hsync, vsync, display_on, frame_tick;
  logic [1:0] r, g, b;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  vga_scroll_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .OFF_W(4), .SPD_W(4), .CHK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .dx(dx), .dy(dy), .pause(pause),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .r(r), .g(g), .b(b), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position derived from elapsed clocks since reset release.
  int t_clk = 0;
  int m_xo = 0, m_yo = 0, m_fc = 0, m_mode = 0;
  int e_h = -1, e_v = -1;
  logic e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_ft = 1'b0;
  logic [1:0] e_r = 2'd0, e_g = 2'd0, e_b = 2'd0;

  function automatic int bt(input int x, input int n);
    return (x >> n) & 1;
  endfunction

  function automatic int wrap16(input int x);
    return ((x % 16) + 16) % 16;
  endfunction

  function automatic int sx4(input logic [3:0] v);
    return (v >= 4'd8) ? int'(v) - 16 : int'(v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_clk = 0; m_xo = 0; m_yo = 0; m_fc = 0; m_mode = 0;
      e_h = -1; e_v = -1;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_ft = 1'b0;
      e_r = 2'd0; e_g = 2'd0; e_b = 2'd0;
    end else begin
      int h, v, mx, my, tx, c;
      h = t_clk % 14;
      v = (t_clk / 14) % 7;
      e_h = h; e_v = v;
      e_de = (h < 8) && (v < 4);
      e_hs = (h == 10 || h == 11) ? 1'b0 : 1'b1;
      e_vs = (v == 5) ? 1'b0 : 1'b1;
      e_ft = (h == 13) && (v == 6);
      mx = wrap16(h + m_xo);
      my = wrap16(v + m_yo);
      tx = mx ^ my;
      c  = bt(mx, 1) ^ bt(my, 1);
      e_r = 2'd0; e_g = 2'd0; e_b = 2'd0;
      if (e_de) begin
        case (m_mode)
          0: begin
            e_r = 2'(2 * bt(mx, 5) + bt(my, 2));
            e_g = 2'(2 * bt(mx, 6) + bt(my, 2));
            e_b = 2'(2 * bt(mx, 7) + bt(my, 5));
          end
          1: begin e_r = 2'(3 * c); e_g = 2'(3 * c); e_b = 2'(3 * c); end
          2: begin e_r = 2'((tx >> 6) & 3); e_g = 2'((tx >> 4) & 3); e_b = 2'((tx >> 2) & 3); end
          default: begin
            e_r = 2'((m_fc >> 6) & 3); e_g = 2'((m_fc >> 4) & 3); e_b = 2'((m_fc >> 2) & 3);
          end
        endcase
      end
      if (e_ft) begin
        m_mode = int'(mode);
        m_fc = (m_fc + 1) % 256;
        if (!pause) begin
          m_xo = wrap16(m_xo + sx4(dx));
          m_yo = wrap16(m_yo + sx4(dy));
        end
      end
      t_clk++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ({hsync, vsync, display_on, r, g, b, frame_tick} !== {e_hs, e_vs, e_de, e_r, e_g, e_b, e_ft}) begin
        bad++;
        $display("FAIL model_cmp at h=%0d v=%0d: got hs=%b vs=%b de=%b rgb=%0d/%0d/%0d ft=%b expected hs=%b vs=%b de=%b rgb=%0d/%0d/%0d ft=%b",
                 e_h, e_v, hsync, vsync, display_on, r, g, b, frame_tick,
                 e_hs, e_vs, e_de, e_r, e_g, e_b, e_ft);
      end
    end
  end

  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_out"}, int'({hsync, vsync, display_on, r, g, b, frame_tick}), int'(11'b110_000000_0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outs("in_reset");
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_tick(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 300);
    if (frame_tick !== 1'b1) begin
      total++; bad++;
      $display("FAIL %s: frame_tick got none expected within 300 clks", nm);
    end
  endtask

  task automatic wait_pos(input int h, input int v, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(e_h == h && e_v == v) && n < 300);
    if (!(e_h == h && e_v == v)) begin
      total++; bad++;
      $display("FAIL %s: position got %0d,%0d expected %0d,%0d", nm, e_h, e_v, h, v);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int xo_seq[6] = '{3, 6, 9, 12, 15, 2};

  initial begin
    int n, vs_low, rgb_off, xo0, yo0, fc0;
    #7 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");

    // First output after release, first hsync low
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_de", int'(display_on), 1);
    n = 1;
    while (hsync === 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("hsync_first_clk", n, 11);

    // Frame period, vsync width, blanking colour
    wait_tick("tick0");
    for (int f = 0; f < 2; f++) begin
      n = 0; vs_low = 0; rgb_off = 0;
      do begin
        @(negedge clk); n++;
        if (vsync === 1'b0) vs_low++;
        if (display_on === 1'b0 && {r, g, b} !== 6'd0) rgb_off++;
      end while (frame_tick !== 1'b1 && n < 300);
      check("ft_period", n, 98);
      check("vsync_low_clks", vs_low, 14);
      check("rgb_blank", rgb_off, 0);
    end

    // X scroll +3 wraps modulo 16
    dx = 4'd3; dy = 4'd1; mode = 2'd2;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wait_tick("xo_tick");
      check($sformatf("xo_seq%0d", i), int'(dut.xo), xo_seq[i]);
    end
    check("yo_after6", int'(dut.yo), 6);
    check("fc_after6", int'(dut.fc), 6);

    // Negative step from zero
    dx = 4'hF; dy = 4'd0;
    do_reset();
    wait_tick("neg_tick");
    check("xo_neg", int'(dut.xo), 15);

    // Pause holds offsets, fc still counts
    wait_pos(3, 2, "pause_pos");
    pause = 1'b1; mode = 2'd3; dy = 4'd5;
    xo0 = int'(dut.xo); yo0 = int'(dut.yo); fc0 = int'(dut.fc);
    wait_tick("pause_t1");
    wait_tick("pause_t2");
    check("pause_xo", int'(dut.xo), xo0);
    check("pause_yo", int'(dut.yo), yo0);
    check("pause_fc", int'(dut.fc), fc0 + 2);
    pause = 1'b0;
    wait_tick("mode3_frame");

    // Mode change mid-frame applies from the next frame
    dx = 4'd0; dy = 4'd0; mode = 2'd0;
    do_reset();
    wait_pos(0, 2, "mode_mid");
    mode = 2'd1;
    wait_pos(0, 3, "mode_old");
    check("mode_old_rgb", int'({r, g, b}), 0);
    wait_pos(2, 0, "mode_new");
    check("mode_new_rgb", int'({r, g, b}), 6'b111111);

    // Asynchronous reset mid-line
    wait_pos(4, 2, "arst_pos");
    #2 rst_n = 1'b0;
    #1;
    check_reset_outs("async_reset");
    check("arst_hc", int'(dut.hc), 0);
    check("arst_vc", int'(dut.vc), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 300);
    check("restart_ft_clk", n, 98);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
